// File: rtl/sram_mem_ctrl_pkg.sv
// Shared constants for the MEM-stage SRAM controller and its pad wrapper:
// FSM state encoding, default memory base, SRAM and wait-counter widths.
package sram_mem_ctrl_pkg;

    localparam int unsigned SRAM_ADDR_W  = 18;
    localparam int unsigned SRAM_DATA_W  = 16;
    localparam int unsigned MEM_BASE_DEF = 1024;
    localparam int unsigned WAIT_W       = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// Pipeline request/response and SRAM pin bundle for sram_mem_ctrl.
//   slave  : controller view (pipeline request in, SRAM pins out)
//   master : environment view (pipeline + SRAM device)
interface sram_mem_ctrl_if
    import sram_mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_LEN      = 32,
    parameter int unsigned ADDRESS_LEN   = 32,
    parameter int unsigned SRAM_ADDR_LEN = SRAM_ADDR_W,
    parameter int unsigned SRAM_DATA_LEN = SRAM_DATA_W
);
    logic                     MEM_R_EN;
    logic                     MEM_W_EN;
    logic [ADDRESS_LEN-1:0]   addr;
    logic [DATA_LEN-1:0]      wdata;
    logic [DATA_LEN-1:0]      rdata;
    logic                     ready;
    logic [SRAM_ADDR_LEN-1:0] sram_addr;
    logic [SRAM_DATA_LEN-1:0] sram_dq_out;
    logic                     sram_dq_oe;
    logic [SRAM_DATA_LEN-1:0] sram_dq_in;
    logic                     sram_we_n;

    modport slave (
        input  MEM_R_EN, MEM_W_EN, addr, wdata, sram_dq_in,
        output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport master (
        output MEM_R_EN, MEM_W_EN, addr, wdata, sram_dq_in,
        input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_wait_counter.sv
// Per-phase wait-state counter: loads WAIT_CYCLES at phase entry and counts
// down to zero; zero marks the last cycle of the phase.
//   clk, rst     : clock, async active-low reset
//   load         : start a new phase
//   en           : count down (saturates at zero)
//   last_c       : current cycle is the last of the phase
//   last_next_c  : next cycle will be the last of the phase
module sram_wait_counter
    import sram_mem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic last_c,
    output logic last_next_c
);
    localparam logic [WAIT_W-1:0] LOAD_VAL = WAIT_W'(WAIT_CYCLES);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Next count
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_c      = (cnt_q == '0);
    assign last_next_c = (cnt_d == '0);

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage data memory responder. Serves 32-bit loads/stores from a 16-bit
// asynchronous SRAM as two half-word phases (LO then HI), each lasting
// WAIT_CYCLES+1 cycles. ready is low while an access is in flight.
//   clk, rst : clock, async active-low reset
//   bus      : pipeline request (MEM_R_EN, MEM_W_EN, addr, wdata),
//              response (rdata, ready) and SRAM pins (sram_addr,
//              sram_dq_out, sram_dq_oe, sram_dq_in, sram_we_n)
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_LEN      = 32,
    parameter int unsigned ADDRESS_LEN   = 32,
    parameter int unsigned SRAM_ADDR_LEN = SRAM_ADDR_W,
    parameter int unsigned SRAM_DATA_LEN = SRAM_DATA_W,
    parameter int unsigned MEM_BASE      = MEM_BASE_DEF,
    parameter int unsigned WAIT_CYCLES   = 2
) (
    input  logic          clk,
    input  logic          rst,
    sram_mem_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = SRAM_ADDR_LEN - 1;

    logic [1:0]               state_q,   state_d;
    logic                     op_wr_q,   op_wr_d;
    logic [IDX_W-1:0]         idx_q,     idx_d;
    logic [DATA_LEN-1:0]      wdata_q,   wdata_d;
    logic [SRAM_DATA_LEN-1:0] lo_q,      lo_d;
    logic [DATA_LEN-1:0]      rdata_q,   rdata_d;
    logic [SRAM_ADDR_LEN-1:0] saddr_q,   saddr_d;
    logic [SRAM_DATA_LEN-1:0] dq_out_q,  dq_out_d;
    logic                     dq_oe_q,   dq_oe_d;
    logic                     we_n_q,    we_n_d;

    logic                     req;
    logic [ADDRESS_LEN-1:0]   offset;
    logic                     cnt_load;
    logic                     cnt_en;
    logic                     cnt_last_c;
    logic                     cnt_last_next_c;
    logic                     phase_d;

    assign req    = bus.MEM_R_EN | bus.MEM_W_EN;
    assign offset = bus.addr - ADDRESS_LEN'(MEM_BASE);

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .clk         (clk),
        .rst         (rst),
        .load        (cnt_load),
        .en          (cnt_en),
        .last_c      (cnt_last_c),
        .last_next_c (cnt_last_next_c)
    );

    // Next state, request latch and registered-output next values
    always_comb begin
        state_d  = state_q;
        op_wr_d  = op_wr_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        rdata_d  = rdata_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d  = ST_LO;
                    op_wr_d  = bus.MEM_W_EN;           // write wins when both set
                    idx_d    = IDX_W'(offset >> 2);    // wraps modulo SRAM size
                    wdata_d  = bus.wdata;
                    cnt_load = 1'b1;
                end
            end
            ST_LO: begin
                if (cnt_last_c) begin
                    state_d  = ST_HI;
                    cnt_load = 1'b1;
                    if (!op_wr_q) begin
                        lo_d = bus.sram_dq_in;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_HI: begin
                if (cnt_last_c) begin
                    state_d = ST_DONE;
                    // Commit the full word at once so rdata only moves on completion
                    if (!op_wr_q) begin
                        rdata_d = {bus.sram_dq_in, lo_q};
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // SRAM pins are registered, so they are derived from next-cycle state
        phase_d  = (state_d == ST_LO) || (state_d == ST_HI);
        saddr_d  = saddr_q;
        dq_out_d = dq_out_q;
        dq_oe_d  = 1'b0;
        we_n_d   = 1'b1;
        if (phase_d) begin
            saddr_d = {idx_d, (state_d == ST_HI)};
            dq_oe_d = op_wr_d;
            // Strobe released on the last cycle of the phase to hold data
            we_n_d  = !(op_wr_d && !cnt_last_next_c);
            if (op_wr_d) begin
                dq_out_d = (state_d == ST_HI) ? wdata_d[DATA_LEN-1:SRAM_DATA_LEN]
                                              : wdata_d[SRAM_DATA_LEN-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_wr_q  <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
            rdata_q  <= '0;
            saddr_q  <= '0;
            dq_out_q <= '0;
            dq_oe_q  <= 1'b0;
            we_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_wr_q  <= op_wr_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            rdata_q  <= rdata_d;
            saddr_q  <= saddr_d;
            dq_out_q <= dq_out_d;
            dq_oe_q  <= dq_oe_d;
            we_n_q   <= we_n_d;
        end
    end

    // Freeze the pipeline from request acceptance until DONE
    assign bus.ready       = (state_q == ST_IDLE) ? !req : (state_q == ST_DONE);
    assign bus.rdata       = rdata_q;
    assign bus.sram_addr   = saddr_q;
    assign bus.sram_dq_out = dq_out_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl: a W=2 instance with an SRAM array
// model and a W=0 instance with an address-derived read pattern.
module tb_sram_mem_ctrl;
    import sram_mem_ctrl_pkg::*;

    localparam int unsigned DL  = 32;
    localparam int unsigned AL  = 32;
    localparam int unsigned SAL = 18;
    localparam int unsigned SDL = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    sram_mem_ctrl_if #(.DATA_LEN(DL), .ADDRESS_LEN(AL), .SRAM_ADDR_LEN(SAL), .SRAM_DATA_LEN(SDL)) bus0 ();
    sram_mem_ctrl_if #(.DATA_LEN(DL), .ADDRESS_LEN(AL), .SRAM_ADDR_LEN(SAL), .SRAM_DATA_LEN(SDL)) bus1 ();

    sram_mem_ctrl #(
        .DATA_LEN(DL), .ADDRESS_LEN(AL), .SRAM_ADDR_LEN(SAL), .SRAM_DATA_LEN(SDL),
        .MEM_BASE(1024), .WAIT_CYCLES(2)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    sram_mem_ctrl #(
        .DATA_LEN(DL), .ADDRESS_LEN(AL), .SRAM_ADDR_LEN(SAL), .SRAM_DATA_LEN(SDL),
        .MEM_BASE(1024), .WAIT_CYCLES(0)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // SRAM device model for dut0
    logic [15:0] sram [0:(1<<18)-1];
    assign bus0.sram_dq_in = sram[bus0.sram_addr];
    always @(posedge clk) begin
        if (bus0.sram_dq_oe && !bus0.sram_we_n) sram[bus0.sram_addr] = bus0.sram_dq_out;
    end

    // dut1 reads a pattern derived from the half-word address
    assign bus1.sram_dq_in = 16'(bus1.sram_addr) + 16'h1000;

    typedef struct {
        int unsigned lat;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
    } stb_t;

    exp_t q0[$];
    exp_t q1[$];
    stb_t sq[$];
    exp_t e0, e1;
    stb_t s0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int unsigned low0 = 0;
    int unsigned low1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got 0x%08h expected no event", name, act);
    endtask

    // Completion monitor for dut0: length of ready-low run, rdata at DONE
    always @(negedge clk) begin
        if (!rst) begin
            low0 = 0;
        end else if (!bus0.ready) begin
            low0++;
        end else if (low0 != 0) begin
            if (q0.size() == 0) begin
                fail_now("unexpected_done0", 32'(low0));
            end else begin
                e0 = q0.pop_front();
                chk("ready_low_cycles0", 32'(low0), 32'(e0.lat));
                chk("rdata0", bus0.rdata, e0.rd);
            end
            low0 = 0;
        end
    end

    // Write-strobe monitor for dut0: every we_n-low cycle must match the queue
    always @(negedge clk) begin
        if (rst && !bus0.sram_we_n) begin
            if (sq.size() == 0) begin
                fail_now("unexpected_strobe", 32'(bus0.sram_addr));
            end else begin
                s0 = sq.pop_front();
                chk("strobe_addr", 32'(bus0.sram_addr), 32'(s0.a));
                chk("strobe_data", 32'(bus0.sram_dq_out), 32'(s0.d));
                chk("strobe_oe", 32'(bus0.sram_dq_oe), 32'd1);
            end
        end
    end

    // Completion monitor for dut1
    always @(negedge clk) begin
        if (!rst) begin
            low1 = 0;
        end else if (!bus1.ready) begin
            low1++;
        end else if (low1 != 0) begin
            if (q1.size() == 0) begin
                fail_now("unexpected_done1", 32'(low1));
            end else begin
                e1 = q1.pop_front();
                chk("ready_low_cycles1", 32'(low1), 32'(e1.lat));
                chk("rdata1", bus1.rdata, e1.rd);
            end
            low1 = 0;
        end
    end

    task automatic set_req0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus0.MEM_R_EN = r;
        bus0.MEM_W_EN = w;
        bus0.addr     = a;
        bus0.wdata    = d;
    endtask

    task automatic push_stb(input logic [17:0] a, input logic [15:0] d, input int n);
        for (int i = 0; i < n; i++) sq.push_back('{a: a, d: d});
    endtask

    // Issue one request on dut0 and hold it until ready is seen high (DONE)
    task automatic access0(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input int unsigned lat, input logic [31:0] rd);
        int n;
        q0.push_back('{lat: lat, rd: rd});
        set_req0(r, w, a, d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus0.ready && n < 50);
        if (!bus0.ready) fail_now("timeout0", 32'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        set_req0(1'b0, 1'b0, bus0.addr, bus0.wdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        set_req0(1'b0, 1'b0, 32'd0, 32'd0);
        bus1.MEM_R_EN = 1'b0;
        bus1.MEM_W_EN = 1'b0;
        bus1.addr     = 32'd0;
        bus1.wdata    = 32'd0;
        sram[4]  = 16'h1234;
        sram[5]  = 16'hABCD;
        sram[16] = 16'h1111;
        sram[17] = 16'h2222;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",   32'(bus0.ready),       32'd1);
        chk("rst_rdata",   bus0.rdata,            32'd0);
        chk("rst_we_n",    32'(bus0.sram_we_n),   32'd1);
        chk("rst_oe",      32'(bus0.sram_dq_oe),  32'd0);
        chk("rst_addr",    32'(bus0.sram_addr),   32'd0);
        chk("rst_dq_out",  32'(bus0.sram_dq_out), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Load from preloaded half-words 4/5
        access0(1'b1, 1'b0, 32'd1032, 32'd0, 7, 32'hABCD1234);
        idle0();

        // Store 0xDEADBEEF to word at half-words 4/5, then read it back
        push_stb(18'd4, 16'hBEEF, 2);
        push_stb(18'd5, 16'hDEAD, 2);
        access0(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 7, 32'hABCD1234);
        idle0();
        access0(1'b1, 1'b0, 32'd1032, 32'd0, 7, 32'hDEADBEEF);
        idle0();

        // Both enables high: treated as a write, rdata untouched
        push_stb(18'd0, 16'hFFFF, 2);
        push_stb(18'd1, 16'h0000, 2);
        access0(1'b1, 1'b1, 32'd1024, 32'h0000FFFF, 7, 32'hDEADBEEF);
        idle0();
        chk("both_sram0", 32'(sram[0]), 32'h0000FFFF);
        chk("both_sram1", 32'(sram[1]), 32'h00000000);

        // Reset during the first HI cycle of a write
        push_stb(18'd16, 16'hAAAA, 2);
        set_req0(1'b0, 1'b1, 32'd1056, 32'h5555AAAA);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        set_req0(1'b0, 1'b0, 32'd1056, 32'h5555AAAA);
        #1;
        chk("abort_we_n",  32'(bus0.sram_we_n),  32'd1);
        chk("abort_oe",    32'(bus0.sram_dq_oe), 32'd0);
        chk("abort_ready", 32'(bus0.ready),      32'd1);
        chk("abort_addr",  32'(bus0.sram_addr),  32'd0);
        chk("abort_rdata", bus0.rdata,           32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        access0(1'b1, 1'b0, 32'd1056, 32'd0, 7, 32'h2222AAAA);
        idle0();

        // Back-to-back store then wrapped load of the same word
        push_stb(18'd0, 16'hF00D, 2);
        push_stb(18'd1, 16'hCAFE, 2);
        access0(1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, 7, 32'h2222AAAA);
        access0(1'b1, 1'b0, 32'd1024 + 32'(1 << 19), 32'd0, 7, 32'hCAFEF00D);
        idle0();

        // Zero-wait-state instance: single load
        q1.push_back('{lat: 3, rd: 32'h10071006});
        bus1.MEM_R_EN = 1'b1;
        bus1.addr     = 32'd1036;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus1.ready && n < 50);
        if (!bus1.ready) fail_now("timeout1", 32'(n));
        @(posedge clk);
        #1;
        bus1.MEM_R_EN = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("stb_drained", 32'(sq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
